// File: rtl/tlb_op_ctrl.sv
// CP0 TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR).
// Drives one TLB port for a cycle, then pulses a CP0 result.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op_code,
  input  logic          flush,
  input  logic [18:0]   cp0_vpn2,
  input  logic [7:0]    cp0_asid,
  input  logic [IW-1:0] cp0_index,
  input  logic          cp0_g,
  input  logic [25:0]   cp0_lo0,
  input  logic [25:0]   cp0_lo1,
  output logic [18:0]   tlb_s_vpn2,
  output logic          tlb_s_odd_page,
  output logic [7:0]    tlb_s_asid,
  input  logic          tlb_s_found,
  input  logic [IW-1:0] tlb_s_index,
  output logic [IW-1:0] tlb_r_index,
  input  logic [18:0]   tlb_r_vpn2,
  input  logic [7:0]    tlb_r_asid,
  input  logic          tlb_r_g,
  input  logic [25:0]   tlb_r_lo0,
  input  logic [25:0]   tlb_r_lo1,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic [18:0]   tlb_w_vpn2,
  output logic [7:0]    tlb_w_asid,
  output logic          tlb_w_g,
  output logic [25:0]   tlb_w_lo0,
  output logic [25:0]   tlb_w_lo1,
  output logic [IW-1:0] random,
  output logic          res_valid,
  output logic [1:0]    res_op,
  output logic          res_probe_miss,
  output logic [IW-1:0] res_index,
  output logic [18:0]   res_vpn2,
  output logic [7:0]    res_asid,
  output logic          res_g,
  output logic [25:0]   res_lo0,
  output logic [25:0]   res_lo1,
  output logic          res_refetch
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          w_accept;

  logic [1:0]    r_op;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic [IW-1:0] r_index;
  logic          r_g;
  logic [25:0]   r_lo0;
  logic [25:0]   r_lo1;
  logic [IW-1:0] r_rand_lat;
  logic [IW-1:0] r_random;

  logic          r_res_miss;
  logic [IW-1:0] r_res_index;
  logic [18:0]   r_res_vpn2;
  logic [7:0]    r_res_asid;
  logic          r_res_g;
  logic [25:0]   r_res_lo0;
  logic [25:0]   r_res_lo1;

  assign op_ready = (r_state == S_IDLE);
  assign w_accept = op_valid & op_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (op_code)
            OP_TLBP:  w_next = S_SEARCH;
            OP_TLBR:  w_next = S_READ;
            OP_TLBWI: w_next = S_WRITE;
            OP_TLBWR: w_next = S_WRITE;
            default:  w_next = S_IDLE;
          endcase
        end
      end
      S_SEARCH: w_next = S_DONE;
      S_READ:   w_next = S_DONE;
      S_WRITE:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operands are frozen at accept so CP0 may change under us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_vpn2     <= '0;
      r_asid     <= '0;
      r_index    <= '0;
      r_g        <= 1'b0;
      r_lo0      <= '0;
      r_lo1      <= '0;
      r_rand_lat <= '0;
    end else if (w_accept) begin
      r_op       <= op_code;
      r_vpn2     <= cp0_vpn2;
      r_asid     <= cp0_asid;
      r_index    <= cp0_index;
      r_g        <= cp0_g;
      r_lo0      <= cp0_lo0;
      r_lo1      <= cp0_lo1;
      r_rand_lat <= r_random;
    end
  end

  // Free-running down counter; power-of-two size wraps for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_random <= IW'(TLBNUM - 1);
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_miss  <= 1'b0;
      r_res_index <= '0;
    end else if (r_state == S_SEARCH) begin
      r_res_miss  <= ~tlb_s_found;
      r_res_index <= tlb_s_found ? tlb_s_index : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_vpn2 <= '0;
      r_res_asid <= '0;
      r_res_g    <= 1'b0;
      r_res_lo0  <= '0;
      r_res_lo1  <= '0;
    end else if (r_state == S_READ) begin
      r_res_vpn2 <= tlb_r_vpn2;
      r_res_asid <= tlb_r_asid;
      r_res_g    <= tlb_r_g;
      r_res_lo0  <= tlb_r_lo0;
      r_res_lo1  <= tlb_r_lo1;
    end
  end

  assign tlb_s_vpn2     = r_vpn2;
  assign tlb_s_asid     = r_asid;
  assign tlb_s_odd_page = 1'b0;
  assign tlb_r_index    = r_index;

  // Combinational from state so reset drops the write at once.
  assign tlb_we      = (r_state == S_WRITE);
  assign tlb_w_index = (r_op == OP_TLBWR) ? r_rand_lat
                                          : r_index;
  assign tlb_w_vpn2  = r_vpn2;
  assign tlb_w_asid  = r_asid;
  assign tlb_w_g     = r_g;
  assign tlb_w_lo0   = r_lo0;
  assign tlb_w_lo1   = r_lo1;

  assign random = r_random;

  assign res_valid      = (r_state == S_DONE);
  assign res_refetch    = res_valid & (r_op != OP_TLBP);
  assign res_op         = r_op;
  assign res_probe_miss = r_res_miss;
  assign res_index      = r_res_index;
  assign res_vpn2       = r_res_vpn2;
  assign res_asid       = r_res_asid;
  assign res_g          = r_res_g;
  assign res_lo0        = r_res_lo0;
  assign res_lo1        = r_res_lo1;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a TLB array stands in for the real one,
// and a separate table of expected entries predicts every result.
module tb_tlb_op_ctrl;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [1:0]    op_code = '0;
  logic          flush = 1'b0;
  logic [18:0]   cp0_vpn2 = '0;
  logic [7:0]    cp0_asid = '0;
  logic [IW-1:0] cp0_index = '0;
  logic          cp0_g = 1'b0;
  logic [25:0]   cp0_lo0 = '0;
  logic [25:0]   cp0_lo1 = '0;
  logic [18:0]   tlb_s_vpn2;
  logic          tlb_s_odd_page;
  logic [7:0]    tlb_s_asid;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic [IW-1:0] tlb_r_index;
  logic [18:0]   tlb_r_vpn2;
  logic [7:0]    tlb_r_asid;
  logic          tlb_r_g;
  logic [25:0]   tlb_r_lo0;
  logic [25:0]   tlb_r_lo1;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic [18:0]   tlb_w_vpn2;
  logic [7:0]    tlb_w_asid;
  logic          tlb_w_g;
  logic [25:0]   tlb_w_lo0;
  logic [25:0]   tlb_w_lo1;
  logic [IW-1:0] random;
  logic          res_valid;
  logic [1:0]    res_op;
  logic          res_probe_miss;
  logic [IW-1:0] res_index;
  logic [18:0]   res_vpn2;
  logic [7:0]    res_asid;
  logic          res_g;
  logic [25:0]   res_lo0;
  logic [25:0]   res_lo1;
  logic          res_refetch;

  tlb_op_ctrl #(.TLBNUM(N)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .flush(flush),
    .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid),
    .cp0_index(cp0_index), .cp0_g(cp0_g),
    .cp0_lo0(cp0_lo0), .cp0_lo1(cp0_lo1),
    .tlb_s_vpn2(tlb_s_vpn2),
    .tlb_s_odd_page(tlb_s_odd_page),
    .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found),
    .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index),
    .tlb_r_vpn2(tlb_r_vpn2), .tlb_r_asid(tlb_r_asid),
    .tlb_r_g(tlb_r_g),
    .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_vpn2(tlb_w_vpn2), .tlb_w_asid(tlb_w_asid),
    .tlb_w_g(tlb_w_g),
    .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
    .random(random),
    .res_valid(res_valid), .res_op(res_op),
    .res_probe_miss(res_probe_miss),
    .res_index(res_index),
    .res_vpn2(res_vpn2), .res_asid(res_asid),
    .res_g(res_g),
    .res_lo0(res_lo0), .res_lo1(res_lo1),
    .res_refetch(res_refetch)
  );

  always #5 clk = ~clk;

  // Stand-in TLB array, written only by the DUT's write port.
  logic [N-1:0] env_v = '0;
  logic [18:0]  env_vpn2 [N];
  logic [7:0]   env_asid [N];
  logic         env_g    [N];
  logic [25:0]  env_lo0  [N];
  logic [25:0]  env_lo1  [N];

  always @(posedge clk) begin
    if (tlb_we) begin
      env_v[tlb_w_index]    <= 1'b1;
      env_vpn2[tlb_w_index] <= tlb_w_vpn2;
      env_asid[tlb_w_index] <= tlb_w_asid;
      env_g[tlb_w_index]    <= tlb_w_g;
      env_lo0[tlb_w_index]  <= tlb_w_lo0;
      env_lo1[tlb_w_index]  <= tlb_w_lo1;
    end
  end

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (env_v[i] && env_vpn2[i] == tlb_s_vpn2 &&
          (env_g[i] || env_asid[i] == tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = IW'(i);
      end
    end
  end

  assign tlb_r_vpn2 = env_v[tlb_r_index] ? env_vpn2[tlb_r_index] : '0;
  assign tlb_r_asid = env_v[tlb_r_index] ? env_asid[tlb_r_index] : '0;
  assign tlb_r_g    = env_v[tlb_r_index] ? env_g[tlb_r_index] : 1'b0;
  assign tlb_r_lo0  = env_v[tlb_r_index] ? env_lo0[tlb_r_index] : '0;
  assign tlb_r_lo1  = env_v[tlb_r_index] ? env_lo1[tlb_r_index] : '0;

  // Expected TLB contents, kept from what each op ought to do.
  logic         ref_v    [N];
  logic [18:0]  ref_vpn2 [N];
  logic [7:0]   ref_asid [N];
  logic         ref_g    [N];
  logic [25:0]  ref_lo0  [N];
  logic [25:0]  ref_lo1  [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] exp_rand();
    return IW'((N - 1) - (cyc % N));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void ref_probe(input logic [18:0] v,
                                    input logic [7:0] a,
                                    output logic hit,
                                    output logic [IW-1:0] idx);
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && ref_v[i] && ref_vpn2[i] == v &&
          (ref_g[i] || ref_asid[i] == a)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  endfunction

  task automatic do_op(input logic [1:0] code,
                       input logic [IW-1:0] idx,
                       input logic [18:0] vpn2,
                       input logic [7:0] asid,
                       input logic g,
                       input logic [25:0] lo0,
                       input logic [25:0] lo1);
    logic [IW-1:0] rnd;
    logic [IW-1:0] widx;
    logic [IW-1:0] hidx;
    logic hit;
    int n;
    n = 0;
    while (!op_ready && n < 8) begin
      tick();
      n++;
    end
    check("ready_before", op_ready, 1);
    rnd = exp_rand();
    op_valid  = 1'b1;
    op_code   = code;
    cp0_index = idx;
    cp0_vpn2  = vpn2;
    cp0_asid  = asid;
    cp0_g     = g;
    cp0_lo0   = lo0;
    cp0_lo1   = lo1;
    tick();
    op_valid  = 1'b0;
    cp0_vpn2  = 19'($urandom);
    cp0_asid  = 8'($urandom);
    cp0_index = IW'($urandom);
    cp0_g     = ~g;
    cp0_lo0   = 26'($urandom);
    cp0_lo1   = 26'($urandom);
    check("busy", op_ready, 0);
    check("rand_busy", random, exp_rand());
    check("we_stage", tlb_we, code[1]);
    check("rv_stage", res_valid, 0);
    if (code[1]) begin
      widx = (code == 2'b11) ? rnd : idx;
      check("w_index", tlb_w_index, widx);
      check("w_vpn2", tlb_w_vpn2, vpn2);
      check("w_asid", tlb_w_asid, asid);
      check("w_g", tlb_w_g, g);
      check("w_lo0", tlb_w_lo0, lo0);
      check("w_lo1", tlb_w_lo1, lo1);
      ref_v[widx]    = 1'b1;
      ref_vpn2[widx] = vpn2;
      ref_asid[widx] = asid;
      ref_g[widx]    = g;
      ref_lo0[widx]  = lo0;
      ref_lo1[widx]  = lo1;
    end else if (code == 2'b00) begin
      check("s_vpn2", tlb_s_vpn2, vpn2);
      check("s_asid", tlb_s_asid, asid);
      check("s_odd", tlb_s_odd_page, 0);
    end else begin
      check("r_index", tlb_r_index, idx);
    end
    tick();
    check("rv_done", res_valid, 1);
    check("res_op", res_op, code);
    check("refetch", res_refetch, code != 2'b00);
    check("we_done", tlb_we, 0);
    if (code == 2'b00) begin
      ref_probe(vpn2, asid, hit, hidx);
      check("probe_miss", res_probe_miss, !hit);
      check("probe_idx", res_index, hit ? hidx : '0);
    end else if (code == 2'b01) begin
      check("r_vpn2", res_vpn2, ref_v[idx] ? ref_vpn2[idx] : '0);
      check("r_asid", res_asid, ref_v[idx] ? ref_asid[idx] : '0);
      check("r_g", res_g, ref_v[idx] ? ref_g[idx] : 1'b0);
      check("r_lo0", res_lo0, ref_v[idx] ? ref_lo0[idx] : '0);
      check("r_lo1", res_lo1, ref_v[idx] ? ref_lo1[idx] : '0);
    end
    tick();
    check("rv_after", res_valid, 0);
    check("refetch_after", res_refetch, 0);
    check("ready_after", op_ready, 1);
  endtask

  logic [18:0] vpool [4];
  logic [7:0]  apool [3];
  int n;

  initial begin
    for (int i = 0; i < N; i++) begin
      ref_v[i]    = 1'b0;
      ref_vpn2[i] = '0;
      ref_asid[i] = '0;
      ref_g[i]    = 1'b0;
      ref_lo0[i]  = '0;
      ref_lo1[i]  = '0;
    end
    vpool[0] = 19'h12345;
    vpool[1] = 19'h00ABC;
    vpool[2] = 19'h7FFFF;
    vpool[3] = 19'h00001;
    apool[0] = 8'h0A;
    apool[1] = 8'h0B;
    apool[2] = 8'h33;

    @(posedge clk);
    #1;
    check("rst_rand", random, 15);
    check("rst_ready", op_ready, 1);
    check("rst_we", tlb_we, 0);
    check("rst_rv", res_valid, 0);
    check("rst_refetch", res_refetch, 0);
    check("rst_miss", res_probe_miss, 0);
    check("rst_index", res_index, 0);
    check("rst_r_index", tlb_r_index, 0);
    reset = 1'b0;
    cyc = 0;

    for (int i = 0; i < 20; i++) begin
      check("rand_seq", random, exp_rand());
      check("idle_ready", op_ready, 1);
      check("idle_we", tlb_we, 0);
      tick();
    end

    do_op(2'b10, 4'd5, 19'h12345, 8'h0A, 1'b0,
          {20'hABCDE, 3'b011, 1'b1, 1'b1},
          {20'h13579, 3'b010, 1'b0, 1'b1});
    do_op(2'b00, 4'd0, 19'h12345, 8'h0A, 1'b0, '0, '0);
    check("tlbp_hit_miss", res_probe_miss, 0);
    check("tlbp_hit_idx", res_index, 5);
    do_op(2'b00, 4'd0, 19'h12345, 8'h0B, 1'b0, '0, '0);
    check("tlbp_asid_miss", res_probe_miss, 1);
    check("tlbp_asid_idx", res_index, 0);
    do_op(2'b10, 4'd7, 19'h00ABC, 8'h01, 1'b1,
          26'h1234567, 26'h0FEDCBA);
    do_op(2'b00, 4'd0, 19'h00ABC, 8'h0B, 1'b0, '0, '0);
    check("tlbp_g_miss", res_probe_miss, 0);
    check("tlbp_g_idx", res_index, 7);
    do_op(2'b01, 4'd5, '0, '0, 1'b0, '0, '0);
    check("tlbr_vpn2", res_vpn2, 19'h12345);
    check("tlbr_asid", res_asid, 8'h0A);
    check("tlbr_lo0", res_lo0, {20'hABCDE, 3'b011, 1'b1, 1'b1});

    n = 0;
    while (exp_rand() != 4'd9 && n < 20) begin
      tick();
      n++;
    end
    check("rand_is_9", random, 9);
    do_op(2'b11, 4'd2, 19'h0BEEF, 8'h44, 1'b0,
          26'h2AAAAAA, 26'h1555555);
    do_op(2'b01, 4'd9, '0, '0, 1'b0, '0, '0);
    check("tlbwr_vpn2", res_vpn2, 19'h0BEEF);

    op_valid = 1'b1;
    op_code  = 2'b10;
    flush    = 1'b1;
    tick();
    check("flush_ready", op_ready, 1);
    check("flush_we", tlb_we, 0);
    tick();
    check("flush_rv", res_valid, 0);
    op_valid = 1'b0;
    flush    = 1'b0;

    for (int k = 0; k < 40; k++) begin
      do_op(2'($urandom_range(0, 3)),
            IW'($urandom_range(0, N - 1)),
            vpool[$urandom_range(0, 3)],
            apool[$urandom_range(0, 2)],
            1'($urandom_range(0, 1)),
            26'($urandom), 26'($urandom));
    end

    op_valid  = 1'b1;
    op_code   = 2'b10;
    cp0_index = 4'd3;
    tick();
    op_valid = 1'b0;
    check("pre_rst_we", tlb_we, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_we", tlb_we, 0);
    check("rst_mid_ready", op_ready, 1);
    check("rst_mid_rv", res_valid, 0);
    check("rst_mid_rand", random, 15);
    tick();
    reset = 1'b0;
    cyc = 0;
    tick();
    check("post_rst_rv", res_valid, 0);
    check("post_rst_rand", random, exp_rand());
    check("no_partial_write", env_v[3], ref_v[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
